// File: rtl/ibufds_deser.sv
// ibufds_deser: differential input buffer with per-channel serial-to-parallel conversion and bit-slip word alignment.
// Latency: O is combinational; the first bit after reset reaches the Q MSB, and Q_VALID pulses after edge DATA_WIDTH.
// Backpressure: none; a BITSLIP cycle holds the word counter, so that period is one bit longer.
// Ports: CLK/RST (async active-high); I/IB diff pairs; BITSLIP shared slip request;
//        O single-ended pass-through; Q packed words (channel c at c*DATA_WIDTH); Q_VALID word strobe;
//        DIFF_ERR sticky per-channel invalid-pair flag.
module ibufds_deser #(
    parameter int                  CHANNELS    = 1,
    parameter int                  DATA_WIDTH  = 8,
    parameter logic [CHANNELS-1:0] IS_INVERTED = {CHANNELS{1'b0}},
    parameter string               DIFF_TERM   = "FALSE",
    parameter string               IOSTANDARD  = "DEFAULT"
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [CHANNELS-1:0]            I,
    input  logic [CHANNELS-1:0]            IB,
    input  logic                           BITSLIP,
    output logic [CHANNELS-1:0]            O,
    output logic [CHANNELS*DATA_WIDTH-1:0] Q,
    output logic                           Q_VALID,
    output logic [CHANNELS-1:0]            DIFF_ERR
);

    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    // Parameter legality is enforced at elaboration time.
    if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
        $error("ibufds_deser: CHANNELS must be in 1..32");
    end
    if (DATA_WIDTH < 2 || DATA_WIDTH > 16) begin : g_bad_width
        $error("ibufds_deser: DATA_WIDTH must be in 2..16");
    end
    // The attributes carry no behaviour, but malformed values are still rejected.
    if (DIFF_TERM != "TRUE" && DIFF_TERM != "FALSE") begin : g_bad_diff_term
        $error("ibufds_deser: DIFF_TERM must be \"TRUE\" or \"FALSE\"");
    end
    if (IOSTANDARD == "") begin : g_bad_iostandard
        $error("ibufds_deser: IOSTANDARD must not be empty");
    end

    logic [CHANNELS-1:0]   pair_ok;
    logic [CHANNELS-1:0]   held;
    logic [CHANNELS-1:0]   d;
    logic [CW-1:0]         cnt;
    // Only the DATA_WIDTH-1 most recent bits are stored. The newest bit
    // comes straight from d, so the oldest bit never needs a flop.
    logic [DATA_WIDTH-2:0] sh   [CHANNELS];
    logic [DATA_WIDTH-1:0] word [CHANNELS];

    assign O       = I ^ IS_INVERTED;
    assign pair_ok = I ^ IB;
    // On an invalid pair (I==IB), the last valid resolved bit is repeated.
    assign d       = (pair_ok & O) | (~pair_ok & held);

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            word[c] = {sh[c], d[c]};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt      <= '0;
            Q        <= '0;
            Q_VALID  <= 1'b0;
            DIFF_ERR <= '0;
            held     <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                sh[c] <= '0;
            end
        end else begin
            // d already equals held on an invalid pair, so held changes only on valid samples.
            held     <= d;
            DIFF_ERR <= DIFF_ERR | ~pair_ok;
            for (int c = 0; c < CHANNELS; c++) begin
                sh[c] <= word[c][DATA_WIDTH-2:0];
            end
            if (BITSLIP) begin
                // The counter holds while shifting continues, so the boundary moves one bit later.
                Q_VALID <= 1'b0;
            end else if (cnt == LAST) begin
                cnt     <= '0;
                Q_VALID <= 1'b1;
                for (int c = 0; c < CHANNELS; c++) begin
                    Q[c*DATA_WIDTH +: DATA_WIDTH] <= word[c];
                end
            end else begin
                cnt     <= cnt + 1'b1;
                Q_VALID <= 1'b0;
            end
        end
    end

endmodule
